hs_width_upsizer: RTL and testbench

HS_WIDTH_UPSIZER -- requirements
Module: hs_width_upsizer

---
 rtl/hs_width_upsizer.sv | 100 ++++++++++
 tb/tb_hs_width_upsizer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/hs_width_upsizer.sv
// Packs RATIO consecutive IN_WIDTH input words into one wide output word,
// little-endian by arrival order, with ilast closing a short final word.
module hs_width_upsizer #(
  parameter int IN_WIDTH    = 8,
  parameter int RATIO       = 4,
  parameter int COUNT_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [IN_WIDTH-1:0]       idata,
  input  logic                      idata_vld,
  input  logic                      ilast,
  output logic                      idata_rdy,
  output logic [IN_WIDTH*RATIO-1:0] odata,
  output logic                      odata_vld,
  input  logic                      odata_rdy,
  output logic                      olast,
  output logic [COUNT_WIDTH-1:0]    ocount
);

  localparam int OUT_W  = IN_WIDTH * RATIO;
  localparam int FILL_W = $clog2(RATIO);

  // Handshake: a word moves on a rising edge where its valid and ready are
  // both high; valid never waits on ready, and idata_rdy never looks at idata_vld.

  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [OUT_W-1:0]       asm_q, asm_d;
  logic [OUT_W-1:0]       odata_q, odata_d;
  logic                   olast_q, olast_d;
  logic [COUNT_WIDTH-1:0] ocount_q, ocount_d;
  logic                   ovld_q, ovld_d;

  logic                   in_xfer;
  logic                   completing;
  logic [OUT_W-1:0]       merged;

  assign idata_rdy  = !ovld_q || odata_rdy;
  assign in_xfer    = idata_vld && idata_rdy;
  assign completing = in_xfer && (ilast || (fill_q == FILL_W'(RATIO - 1)));

  // Lanes above fill are always zero, so merging only touches lane fill.
  always_comb begin
    merged = asm_q;
    for (int k = 0; k < RATIO; k++) begin
      if (fill_q == FILL_W'(k)) begin
        merged[k*IN_WIDTH +: IN_WIDTH] = idata;
      end
    end
  end

  always_comb begin
    fill_d   = fill_q;
    asm_d    = asm_q;
    odata_d  = odata_q;
    olast_d  = olast_q;
    ocount_d = ocount_q;
    ovld_d   = ovld_q;
    if (ovld_q && odata_rdy) begin
      ovld_d = 1'b0;
    end
    if (in_xfer) begin
      if (completing) begin
        odata_d  = merged;
        ocount_d = COUNT_WIDTH'(fill_q) + COUNT_WIDTH'(1);
        olast_d  = ilast;
        ovld_d   = 1'b1;
        asm_d    = '0;
        fill_d   = '0;
      end else begin
        asm_d  = merged;
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fill_q   <= '0;
      asm_q    <= '0;
      odata_q  <= '0;
      olast_q  <= 1'b0;
      ocount_q <= '0;
      ovld_q   <= 1'b0;
    end else begin
      fill_q   <= fill_d;
      asm_q    <= asm_d;
      odata_q  <= odata_d;
      olast_q  <= olast_d;
      ocount_q <= ocount_d;
      ovld_q   <= ovld_d;
    end
  end

  assign odata     = odata_q;
  assign olast     = olast_q;
  assign ocount    = ocount_q;
  assign odata_vld = ovld_q;

endmodule

// File: tb/tb_hs_width_upsizer.sv
// Directed bench for hs_width_upsizer (IN_WIDTH=8, RATIO=4): step checks plus
// an in-order scoreboard on every output transfer.
module tb_hs_width_upsizer;

  logic        clk;
  logic        rst;
  logic [7:0]  idata;
  logic        idata_vld;
  logic        ilast;
  logic        idata_rdy;
  logic [31:0] odata;
  logic        odata_vld;
  logic        odata_rdy;
  logic        olast;
  logic [2:0]  ocount;

  int checks = 0;
  int errors = 0;
  logic [35:0] exp_q[$];

  hs_width_upsizer #(.IN_WIDTH(8), .RATIO(4), .COUNT_WIDTH(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .idata     (idata),
    .idata_vld (idata_vld),
    .ilast     (ilast),
    .idata_rdy (idata_rdy),
    .odata     (odata),
    .odata_vld (odata_vld),
    .odata_rdy (odata_rdy),
    .olast     (olast),
    .ocount    (ocount)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic last);
    idata     = d;
    ilast     = last;
    idata_vld = 1'b1;
    #1;
    check("send_rdy", 64'(idata_rdy), 64'd1);
    tick();
    idata_vld = 1'b0;
  endtask

  task automatic check_out(input string tag, input logic [31:0] d, input logic [2:0] cnt,
                           input logic last);
    check({tag, "_vld"}, 64'(odata_vld), 64'd1);
    check({tag, "_data"}, 64'(odata), 64'(d));
    check({tag, "_cnt"}, 64'(ocount), 64'(cnt));
    check({tag, "_last"}, 64'(olast), 64'(last));
  endtask

  // scoreboard: every output transfer must match the next expected word
  always @(posedge clk) begin
    if (!rst && odata_vld && odata_rdy) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL sb_extra obs=%0h exp=none", {olast, ocount, odata});
      end else begin
        check("sb_word", 64'({olast, ocount, odata}), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    rst       = 1'b1;
    idata     = 8'h00;
    idata_vld = 1'b0;
    ilast     = 1'b0;
    odata_rdy = 1'b0;

    // reset state before any clock edge
    #3;
    check("rst_vld", 64'(odata_vld), 64'd0);
    check("rst_data", 64'(odata), 64'd0);
    check("rst_cnt", 64'(ocount), 64'd0);
    check("rst_last", 64'(olast), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_rdy", 64'(idata_rdy), 64'd1);

    // full packet 01..04 closed by ilast
    odata_rdy = 1'b1;
    exp_q.push_back({1'b1, 3'd4, 32'h04030201});
    send(8'h01, 1'b0);
    check("t1_vld0", 64'(odata_vld), 64'd0);
    send(8'h02, 1'b0);
    check("t1_vld1", 64'(odata_vld), 64'd0);
    send(8'h03, 1'b0);
    check("t1_vld2", 64'(odata_vld), 64'd0);
    send(8'h04, 1'b1);
    check_out("t1", 32'h04030201, 3'd4, 1'b1);

    // short packet, then next packet begins in lane 0
    exp_q.push_back({1'b1, 3'd2, 32'h0000BBAA});
    exp_q.push_back({1'b1, 3'd4, 32'h44332211});
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check_out("t2a", 32'h0000BBAA, 3'd2, 1'b1);
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b1);
    check_out("t2b", 32'h44332211, 3'd4, 1'b1);

    // continuous stream of 8 words, no ilast
    exp_q.push_back({1'b0, 3'd4, 32'h03020100});
    exp_q.push_back({1'b0, 3'd4, 32'h07060504});
    for (int i = 0; i < 8; i++) begin
      send(8'(i), 1'b0);
      if (i == 3) check_out("t3a", 32'h03020100, 3'd4, 1'b0);
    end
    check_out("t3b", 32'h07060504, 3'd4, 1'b0);
    tick();
    check("t3_idle", 64'(odata_vld), 64'd0);

    // backpressure: output stalls 5 cycles with next word waiting
    exp_q.push_back({1'b0, 3'd4, 32'h13121110});
    exp_q.push_back({1'b0, 3'd4, 32'h23222120});
    exp_q.push_back({1'b1, 3'd1, 32'h00000040});
    exp_q.push_back({1'b1, 3'd1, 32'h00000041});
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    odata_rdy = 1'b0;
    idata     = 8'h20;
    ilast     = 1'b0;
    idata_vld = 1'b1;
    #1;
    check("t4_rdy_low", 64'(idata_rdy), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_out("t4_stall", 32'h13121110, 3'd4, 1'b0);
      check("t4_stall_rdy", 64'(idata_rdy), 64'd0);
    end
    odata_rdy = 1'b1;
    #1;
    check("t4_rdy_back", 64'(idata_rdy), 64'd1);
    tick();
    idata_vld = 1'b0;
    check("t4_drain", 64'(odata_vld), 64'd0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    check_out("t4b", 32'h23222120, 3'd4, 1'b0);
    // completing transfers that coincide with output transfers
    send(8'h40, 1'b1);
    check_out("t4c", 32'h00000040, 3'd1, 1'b1);
    send(8'h41, 1'b1);
    check_out("t4d", 32'h00000041, 3'd1, 1'b1);
    tick();
    check("t4_idle", 64'(odata_vld), 64'd0);

    // reset discards an unaccepted output word
    odata_rdy = 1'b0;
    send(8'h70, 1'b1);
    check_out("t5_pend", 32'h00000070, 3'd1, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("t5_rst_vld", 64'(odata_vld), 64'd0);
    check("t5_rst_data", 64'(odata), 64'd0);
    check("t5_rst_cnt", 64'(ocount), 64'd0);
    check("t5_rst_last", 64'(olast), 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("t5_rdy", 64'(idata_rdy), 64'd1);

    // reset mid-packet discards the partial word
    odata_rdy = 1'b1;
    send(8'h50, 1'b0);
    send(8'h51, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("t6_rst_vld", 64'(odata_vld), 64'd0);
    tick();
    rst = 1'b0;
    exp_q.push_back({1'b0, 3'd4, 32'h83828180});
    send(8'h80, 1'b0);
    send(8'h81, 1'b0);
    send(8'h82, 1'b0);
    send(8'h83, 1'b0);
    check_out("t6", 32'h83828180, 3'd4, 1'b0);
    tick();
    check("t6_idle", 64'(odata_vld), 64'd0);
    tick();

    check("sb_left", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
